// File: rtl/pc_call_stack_if.sv
// Control-strobe and status bundle between the sequencer controller and the program counter.
interface pc_call_stack_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned PTR_WIDTH  = 4
);
  logic                  reset;
  logic                  load;
  logic [ADDR_WIDTH-1:0] load_data;
  logic                  increment;
  logic                  call;
  logic                  ret;
  logic                  err_clear;
  logic [ADDR_WIDTH-1:0] counter;
  logic [ADDR_WIDTH-1:0] return_addr;
  logic [PTR_WIDTH-1:0]  depth;
  logic                  stack_empty;
  logic                  stack_full;
  logic                  stack_overflow;
  logic                  stack_underflow;

  modport master (
    output reset, load, load_data, increment, call, ret, err_clear,
    input  counter, return_addr, depth, stack_empty, stack_full,
           stack_overflow, stack_underflow
  );

  modport slave (
    input  reset, load, load_data, increment, call, ret, err_clear,
    output counter, return_addr, depth, stack_empty, stack_full,
           stack_overflow, stack_underflow
  );
endinterface

// File: rtl/pc_call_stack.sv
// Program counter with a LIFO hardware return-address stack for CALL/RET,
// depth reporting and sticky overflow/underflow flags.
module pc_call_stack #(
  parameter int unsigned           ADDR_WIDTH  = 8,
  parameter int unsigned           STACK_DEPTH = 8,
  parameter int unsigned           PTR_WIDTH   = $clog2(STACK_DEPTH) + 1,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0
) (
  input logic           clk,
  input logic           a_reset_n,
  pc_call_stack_if.slave bus
);

  localparam int unsigned          IDX_WIDTH = $clog2(STACK_DEPTH);
  localparam logic [PTR_WIDTH-1:0] DEPTH_MAX = PTR_WIDTH'(STACK_DEPTH);

  logic [ADDR_WIDTH-1:0] counter_q, counter_d;
  logic [PTR_WIDTH-1:0]  depth_q, depth_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];

  logic                  push_en;
  logic [IDX_WIDTH-1:0]  push_idx;
  logic [IDX_WIDTH-1:0]  top_idx;
  logic [ADDR_WIDTH-1:0] counter_inc;
  logic [ADDR_WIDTH-1:0] top_entry;
  logic                  is_empty;
  logic                  is_full;

  // Decodes of registered state used by both the command logic and the outputs.
  assign counter_inc = counter_q + ADDR_WIDTH'(1);
  assign is_empty    = (depth_q == '0);
  assign is_full     = (depth_q == DEPTH_MAX);
  assign push_idx    = IDX_WIDTH'(depth_q);
  assign top_idx     = IDX_WIDTH'(depth_q - PTR_WIDTH'(1));
  assign top_entry   = stack_mem[top_idx];

  // Command resolution: reset > ret > call > load > increment; error events beat err_clear.
  always_comb begin
    counter_d   = counter_q;
    depth_d     = depth_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    push_en     = 1'b0;

    if (bus.reset) begin
      counter_d   = RESET_ADDR;
      depth_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (bus.err_clear) begin
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
      end

      if (bus.ret) begin
        if (!is_empty) begin
          counter_d = top_entry;
          depth_d   = depth_q - PTR_WIDTH'(1);
        end else begin
          underflow_d = 1'b1;
        end
      end else if (bus.call) begin
        if (!is_full) begin
          push_en   = 1'b1;
          counter_d = bus.load_data;
          depth_d   = depth_q + PTR_WIDTH'(1);
        end else begin
          overflow_d = 1'b1;
        end
      end else if (bus.load) begin
        counter_d = bus.load_data;
      end else if (bus.increment) begin
        counter_d = counter_inc;
      end
    end
  end

  // Control state: counter, depth and sticky flags.
  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      counter_q   <= RESET_ADDR;
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      counter_q   <= counter_d;
      depth_q     <= depth_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Stack storage is left unreset; depth alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_mem[push_idx] <= counter_inc;
    end
  end

  assign bus.counter         = counter_q;
  assign bus.depth           = depth_q;
  assign bus.return_addr     = is_empty ? '0 : top_entry;
  assign bus.stack_empty     = is_empty;
  assign bus.stack_full      = is_full;
  assign bus.stack_overflow  = overflow_q;
  assign bus.stack_underflow = underflow_q;

endmodule
